// File: rtl/mod_timer_ctrl_if.sv
// Control and status bundle of the mod_timer_ctrl period timer.
interface mod_timer_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             pause;
  logic             stop;
  logic             oneshot;
  logic             cfg_wr;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             done;
  logic             busy;
  logic             cfg_err;
  logic [7:0]       wrap_cnt;

  modport master (
    output start, pause, stop, oneshot, cfg_wr, cfg_period,
    input  q, tick, done, busy, cfg_err, wrap_cnt
  );

  modport slave (
    input  start, pause, stop, oneshot, cfg_wr, cfg_period,
    output q, tick, done, busy, cfg_err, wrap_cnt
  );
endinterface

// File: rtl/mod_timer_ctrl.sv
// Start/pause/stop period timer with shadowed period reload and tick/done pulses.
// Optional saturating wrap counter is built when MOD_TIMER_WRAP_CNT_EN is defined.
module mod_timer_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEF_PERIOD = 50223
) (
  input  logic            clk,
  input  logic            rst_n,
  mod_timer_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W      = 8;
  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic [WIDTH-1:0] period, period_nx;
  logic [WIDTH-1:0] shadow, shadow_nx;
  logic             shadow_vld, shadow_vld_nx;
  logic             wrap_la, wrap_la_nx;
  logic             os_mode, os_mode_nx;
  logic             done_r, done_nx;
  logic             cfg_err_r, cfg_err_nx;
  logic             busy_r, busy_nx;
  logic             cfg_ok, apply_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      q_r        <= '0;
      period     <= WIDTH'(DEF_PERIOD);
      shadow     <= '0;
      shadow_vld <= 1'b0;
      wrap_la    <= 1'b0;
      os_mode    <= 1'b0;
      done_r     <= 1'b0;
      cfg_err_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      q_r        <= q_nx;
      period     <= period_nx;
      shadow     <= shadow_nx;
      shadow_vld <= shadow_vld_nx;
      wrap_la    <= wrap_la_nx;
      os_mode    <= os_mode_nx;
      done_r     <= done_nx;
      cfg_err_r  <= cfg_err_nx;
      busy_r     <= busy_nx;
    end
  end

  // wrap_la marks "q is P-1 in RUN": it drives tick and selects the wrap without comparing q
  always_comb begin
    state_nx      = state;
    q_nx          = q_r;
    period_nx     = period;
    shadow_nx     = shadow;
    shadow_vld_nx = shadow_vld;
    wrap_la_nx    = 1'b0;
    os_mode_nx    = os_mode;
    done_nx       = 1'b0;
    apply_cfg     = 1'b0;
    cfg_ok        = bus.cfg_wr && (bus.cfg_period >= MIN_PERIOD);
    cfg_err_nx    = bus.cfg_wr && !cfg_ok;

    case (state)
      IDLE: begin
        q_nx = '0;
        if (cfg_ok) period_nx = bus.cfg_period;
        if (!bus.stop && bus.start) begin
          state_nx   = RUN;
          os_mode_nx = bus.oneshot;
        end
      end
      RUN: begin
        if (cfg_ok) begin
          shadow_nx     = bus.cfg_period;
          shadow_vld_nx = 1'b1;
        end
        if (bus.stop) begin
          state_nx  = IDLE;
          q_nx      = '0;
          apply_cfg = 1'b1;
        end else if (bus.pause) begin
          state_nx = PAUSE;
        end else if (wrap_la) begin
          q_nx      = '0;
          apply_cfg = 1'b1;
          if (os_mode) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end else begin
          q_nx       = q_r + WIDTH'(1);
          wrap_la_nx = (q_r == period - WIDTH'(2));
        end
      end
      PAUSE: begin
        if (cfg_ok) begin
          shadow_nx     = bus.cfg_period;
          shadow_vld_nx = 1'b1;
        end
        if (bus.stop) begin
          state_nx  = IDLE;
          q_nx      = '0;
          apply_cfg = 1'b1;
        end else if (bus.start) begin
          state_nx   = RUN;
          wrap_la_nx = (q_r == period - WIDTH'(1));
        end
      end
      default: begin
        state_nx = IDLE;
        q_nx     = '0;
      end
    endcase

    // A write landing on the reload edge is the most recent one, so it beats the shadow
    if (apply_cfg) begin
      shadow_vld_nx = 1'b0;
      if (cfg_ok)          period_nx = bus.cfg_period;
      else if (shadow_vld) period_nx = shadow;
    end

    busy_nx = (state_nx != IDLE);
  end

  assign bus.q       = q_r;
  assign bus.tick    = wrap_la;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.cfg_err = cfg_err_r;

`ifdef MOD_TIMER_WRAP_CNT_EN
  logic [CNT_W-1:0] wrap_cnt_r;
  logic             cnt_clr, cnt_inc;

  assign cnt_clr = (state == IDLE) && !bus.stop && bus.start;
  assign cnt_inc = (state == RUN) && !bus.stop && !bus.pause && wrap_la;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wrap_cnt_r <= '0;
    else if (cnt_clr)                    wrap_cnt_r <= '0;
    else if (cnt_inc && wrap_cnt_r != '1) wrap_cnt_r <= wrap_cnt_r + CNT_W'(1);
  end

  assign bus.wrap_cnt = wrap_cnt_r;
`else
  assign bus.wrap_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_mod_timer_ctrl.sv
// Scoreboarded bench for mod_timer_ctrl; expectations come from a cycle model kept in the bench.
module tb_mod_timer_ctrl;
  localparam int unsigned W     = 16;
  localparam int unsigned DEF_P = 7;
`ifdef MOD_TIMER_WRAP_CNT_EN
  localparam int WC_FINAL = 255;
`else
  localparam int WC_FINAL = 0;
`endif

  typedef struct packed {
    logic         start, pause, stop, oneshot, cfg_wr;
    logic [W-1:0] cfg_period;
  } stim_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tick, done, busy, cfg_err;
    logic [7:0]   wc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t sb[$];

  // model state: m_st 0=IDLE 1=RUN 2=PAUSE
  int m_st, m_q, m_p, m_sh, m_wc;
  bit m_shv, m_os, m_done, m_err;

  mod_timer_ctrl_if #(.WIDTH(W)) bus ();

  mod_timer_ctrl #(.WIDTH(W), .DEF_PERIOD(DEF_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(bit st, bit pa, bit sp, bit os, bit cw, int cp);
    stim_t s;
    s.start = st; s.pause = pa; s.stop = sp; s.oneshot = os; s.cfg_wr = cw;
    s.cfg_period = W'(cp);
    return s;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("q=%0d tick=%b done=%b busy=%b cfg_err=%b wrap_cnt=%0d",
                     o.q, o.tick, o.done, o.busy, o.cfg_err, o.wc);
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.q = bus.q; o.tick = bus.tick; o.done = bus.done; o.busy = bus.busy;
    o.cfg_err = bus.cfg_err; o.wc = bus.wrap_cnt;
    return o;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_q = 0; m_p = DEF_P; m_sh = 0; m_wc = 0;
    m_shv = 1'b0; m_os = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.q       = W'(m_q);
    o.tick    = (m_st == 1) && (m_q == m_p - 1);
    o.done    = m_done;
    o.busy    = (m_st != 0);
    o.cfg_err = m_err;
`ifdef MOD_TIMER_WRAP_CNT_EN
    o.wc      = 8'(m_wc);
`else
    o.wc      = 8'd0;
`endif
    return o;
  endfunction

  function automatic obs_t model_step(input stim_t s);
    bit ok, reload;
    ok     = s.cfg_wr && (int'(s.cfg_period) >= 2);
    reload = 1'b0;
    m_done = 1'b0;
    m_err  = s.cfg_wr && !ok;
    if (ok && m_st == 0) m_p = int'(s.cfg_period);
    else if (ok) begin m_sh = int'(s.cfg_period); m_shv = 1'b1; end
    if (s.stop) begin
      reload = (m_st != 0); m_st = 0; m_q = 0;
    end else if (m_st == 0) begin
      if (s.start) begin m_st = 1; m_q = 0; m_os = s.oneshot; m_wc = 0; end
    end else if (m_st == 1) begin
      if (s.pause) m_st = 2;
      else if (m_q == m_p - 1) begin
        m_q = 0; reload = 1'b1;
        if (m_wc < 255) m_wc++;
        if (m_os) begin m_st = 0; m_done = 1'b1; end
      end else m_q++;
    end else if (s.start) m_st = 1;
    if (reload && m_shv) begin m_p = m_sh; m_shv = 1'b0; end
    return model_obs();
  endfunction

  task automatic apply(input stim_t s);
    bus.start = s.start; bus.pause = s.pause; bus.stop = s.stop;
    bus.oneshot = s.oneshot; bus.cfg_wr = s.cfg_wr; bus.cfg_period = s.cfg_period;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.oneshot = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_period = '0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    model_reset();
    sb.push_back('0);
    #7;
    got = dut_obs(); e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL reset: got %s want %s", fmt(got), fmt(e));
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_default_period();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 1, 0, 0));
    repeat (8) sq.push_back('0);
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL default_period[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(0, 0, 0, 0, 1, 5));
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (13) sq.push_back('0);
    sq.push_back(mk(0, 0, 1, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL continuous[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 1, 1, 4));
    repeat (5) sq.push_back('0);
    sq.push_back(mk(0, 1, 0, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL oneshot[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 0, 1, 10));
    repeat (6) sq.push_back('0);
    sq.push_back(mk(0, 1, 0, 0, 0, 0));
    repeat (2) sq.push_back('0);
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (3) sq.push_back('0);
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (9) sq.push_back('0);
    sq.push_back(mk(0, 1, 0, 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    sq.push_back('0);
    sq.push_back(mk(0, 0, 1, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL pause[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_shadow();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 0, 1, 8));
    repeat (2) sq.push_back('0);
    sq.push_back(mk(0, 0, 0, 0, 1, 3));
    repeat (7) sq.push_back('0);
    sq.push_back(mk(0, 0, 0, 0, 1, 1));
    repeat (3) sq.push_back('0);
    sq.push_back(mk(0, 0, 0, 0, 1, 6));
    sq.push_back(mk(0, 0, 0, 0, 1, 4));
    repeat (5) sq.push_back('0);
    sq.push_back(mk(0, 0, 0, 0, 1, 5));
    sq.push_back(mk(0, 0, 1, 0, 0, 0));
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (5) sq.push_back('0);
    sq.push_back(mk(0, 0, 1, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL shadow[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_stop_start();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 0, 1, 6));
    repeat (3) sq.push_back('0);
    sq.push_back(mk(1, 0, 1, 0, 0, 0));
    sq.push_back('0);
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    sq.push_back('0);
    sq.push_back(mk(0, 1, 1, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL stop_start[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    stim_t sq[$]; obs_t got, e;
    sq.push_back(mk(1, 0, 0, 0, 1, 9));
    repeat (5) sq.push_back('0);
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL async_reset_pre[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
    // drop reset between edges: outputs must clear without a clock
    #2 rst_n = 1'b0;
    model_reset();
    sb.push_back('0);
    #1;
    got = dut_obs(); e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL async_reset_mid: got %s want %s", fmt(got), fmt(e));
    else n_pass++;
    #2 rst_n = 1'b1;
    sq.delete();
    sq.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (8) sq.push_back('0);
    sq.push_back(mk(0, 0, 1, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(model_step(sq[i])); apply(sq[i]);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL async_reset_post[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
    end
  endtask

  task automatic test_p2_sat();
    stim_t s; obs_t got, e;
    for (int i = 0; i < 602; i++) begin
      if (i == 0)        s = mk(1, 0, 0, 0, 1, 2);
      else if (i == 601) s = mk(0, 0, 1, 0, 0, 0);
      else               s = '0;
      sb.push_back(model_step(s)); apply(s);
      got = dut_obs(); e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL p2_sat[%0d]: got %s want %s", i, fmt(got), fmt(e));
      else n_pass++;
      if (i == 600) begin
        n_chk++;
        if (bus.wrap_cnt !== 8'(WC_FINAL))
          $display("FAIL p2_wrap_cnt_final: got %0d want %0d", bus.wrap_cnt, WC_FINAL);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.oneshot = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_period = '0;
    test_reset();
    test_default_period();
    test_continuous();
    test_oneshot();
    test_pause();
    test_shadow();
    test_stop_start();
    test_async_reset();
    test_p2_sat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
